// File: rtl/sort_pkg.sv
// Shared definitions for the sort path (insertion sorter and result collector):
// default word width, frame depth, index width and the collector state encoding.
package sort_pkg;

  localparam int SORT_DATA_W    = 32;
  localparam int SORT_MAX_COUNT = 101;

  // Index counter width; covers 0..SORT_MAX_COUNT.
  localparam int IDX_W = $clog2(SORT_MAX_COUNT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    REPORT  = 2'd2
  } state_t;

endpackage

// File: rtl/sort_stat_acc.sv
// Per-frame statistics datapath: running min, max, order check and optional sum.
// Optional feature macro: SORT_SUM_EN builds the sum accumulator; without it
// res_sum is tied to zero.
module sort_stat_acc
  import sort_pkg::*;
#(
  parameter int DATA_W = SORT_DATA_W,
  parameter int SUM_W  = 40
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              beat,
  input  logic              first,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] res_min,
  output logic [DATA_W-1:0] res_max,
  output logic [SUM_W-1:0]  res_sum,
  output logic              err_order
);

  logic [DATA_W-1:0] prev;

  // Track min/max and flag any word smaller than the one before it.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      res_min   <= '0;
      res_max   <= '0;
      prev      <= '0;
      err_order <= 1'b0;
    end else if (beat) begin
      if (first) begin
        res_min <= data;
        res_max <= data;
      end else begin
        if (data < res_min) res_min <= data;
        if (data > res_max) res_max <= data;
        if (data < prev)    err_order <= 1'b1;
      end
      prev <= data;
    end
  end

`ifdef SORT_SUM_EN
  // Accumulate the frame sum; narrower-than-default builds wrap modulo 2^SUM_W.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      res_sum <= '0;
    end else if (beat) begin
      res_sum <= first ? SUM_W'(data) : res_sum + SUM_W'(data);
    end
  end
`else
  assign res_sum = '0;
`endif

endmodule

// File: rtl/sort_result_collector.sv
// Checker and statistics tail of the sort path: collects one sorted frame,
// reports min/max/median/sum and ordering/length errors behind done/ack.
// Optional feature macro: SORT_SUM_EN (sum accumulator in sort_stat_acc).
//
// state   | meaning
// IDLE    | waiting for start; previous results remain readable
// COLLECT | accepting in_valid beats until count words have arrived
// REPORT  | done high, results frozen until ack
module sort_result_collector
  import sort_pkg::*;
#(
  parameter int DATA_W    = SORT_DATA_W,
  parameter int MAX_COUNT = SORT_MAX_COUNT,
  parameter int SUM_W     = 40
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       count,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              ack,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] res_min,
  output logic [DATA_W-1:0] res_max,
  output logic [DATA_W-1:0] res_median,
  output logic [SUM_W-1:0]  res_sum,
  output logic              err_order,
  output logic              err_count
);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] last_idx;
  logic [IDX_W-1:0] med_idx;
  logic [IDX_W-1:0] count_m1;
  logic             count_ok;
  logic             stat_clear;
  logic             stat_beat;
  logic             stat_first;

  assign count_ok   = (count != 32'd0) && (count <= 32'(MAX_COUNT));
  assign count_m1   = count[IDX_W-1:0] - IDX_W'(1);
  assign stat_clear = (state == IDLE) && start;
  assign stat_beat  = (state == COLLECT) && in_valid;
  assign stat_first = (idx == '0);

  // Frame sequencing, index counter, median capture and registered status.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      last_idx   <= '0;
      med_idx    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_count  <= 1'b0;
      res_median <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx        <= '0;
            res_median <= '0;
            if (count_ok) begin
              state     <= COLLECT;
              busy      <= 1'b1;
              err_count <= 1'b0;
              last_idx  <= count_m1;
              med_idx   <= count_m1 >> 1;
            end else begin
              state     <= REPORT;
              done      <= 1'b1;
              err_count <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (in_valid) begin
            if (idx == med_idx) res_median <= in_data;
            idx <= idx + IDX_W'(1);
            if (idx == last_idx) begin
              state <= REPORT;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        REPORT: begin
          if (ack) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  sort_stat_acc #(
    .DATA_W (DATA_W),
    .SUM_W  (SUM_W)
  ) u_stat (
    .clk       (clk),
    .reset     (reset),
    .clear     (stat_clear),
    .beat      (stat_beat),
    .first     (stat_first),
    .data      (in_data),
    .res_min   (res_min),
    .res_max   (res_max),
    .res_sum   (res_sum),
    .err_order (err_order)
  );

endmodule

// File: tb/tb_sort_result_collector.sv
// Scoreboard bench for sort_result_collector: directed frames push expected
// results; a monitor compares them when done rises.
module tb_sort_result_collector;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] count;
  logic        in_valid;
  logic [31:0] in_data;
  logic        ack;
  logic        busy;
  logic        done;
  logic [31:0] res_min;
  logic [31:0] res_max;
  logic [31:0] res_median;
  logic [39:0] res_sum;
  logic        err_order;
  logic        err_count;

  int n_cmp = 0;
  int n_err = 0;

`ifdef SORT_SUM_EN
  localparam bit SUM_ON = 1'b1;
`else
  localparam bit SUM_ON = 1'b0;
`endif

  typedef struct {
    logic [31:0] mn;
    logic [31:0] mx;
    logic [31:0] med;
    logic [39:0] sum;
    logic        eo;
    logic        ec;
  } exp_t;

  exp_t exp_q[$];

  sort_result_collector dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .count      (count),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .ack        (ack),
    .busy       (busy),
    .done       (done),
    .res_min    (res_min),
    .res_max    (res_max),
    .res_median (res_median),
    .res_sum    (res_sum),
    .err_order  (err_order),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void push_exp(input logic [31:0] mn, input logic [31:0] mx,
                                   input logic [31:0] med, input logic [39:0] sum,
                                   input logic eo, input logic ec);
    exp_t e;
    e.mn  = mn;
    e.mx  = mx;
    e.med = med;
    e.sum = SUM_ON ? sum : 40'd0;
    e.eo  = eo;
    e.ec  = ec;
    exp_q.push_back(e);
  endfunction

  // Monitor: on each rising done, pop the oldest expectation and compare.
  initial begin
    logic done_q;
    exp_t e;
    done_q = 1'b0;
    forever begin
      @(negedge clk);
      if (done && !done_q) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 64'(done), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("res_min",    64'(res_min),    64'(e.mn));
          chk("res_max",    64'(res_max),    64'(e.mx));
          chk("res_median", 64'(res_median), 64'(e.med));
          chk("res_sum",    64'(res_sum),    64'(e.sum));
          chk("err_order",  64'(err_order),  64'(e.eo));
          chk("err_count",  64'(err_count),  64'(e.ec));
          chk("busy_in_report", 64'(busy), 64'd0);
        end
      end
      done_q = done;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] c);
    start = 1'b1;
    count = c;
    step();
    start = 1'b0;
    count = 32'hDEAD_BEEF;
  endtask

  task automatic beat(input logic [31:0] d, input bit last);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
    in_data  = $urandom;
    chk(last ? "done_after_last" : "done_early", 64'(done), 64'(last));
  endtask

  task automatic do_ack();
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("done_after_ack", 64'(done), 64'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},   64'(busy),       64'd0);
    chk({tag, "_done"},   64'(done),       64'd0);
    chk({tag, "_min"},    64'(res_min),    64'd0);
    chk({tag, "_max"},    64'(res_max),    64'd0);
    chk({tag, "_median"}, 64'(res_median), 64'd0);
    chk({tag, "_sum"},    64'(res_sum),    64'd0);
    chk({tag, "_eo"},     64'(err_order),  64'd0);
    chk({tag, "_ec"},     64'(err_count),  64'd0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #400000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Directed stimulus.
  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    count    = 32'd0;
    in_valid = 1'b0;
    in_data  = 32'd0;
    ack      = 1'b0;
    repeat (3) step();
    chk_all_zero("reset");
    reset = 1'b0;
    step();

    // Frame 1: 1,2,3,4; ack arrives after one idle REPORT cycle.
    push_exp(32'd1, 32'd4, 32'd2, 40'd10, 1'b0, 1'b0);
    do_start(32'd4);
    chk("busy_after_start", 64'(busy), 64'd1);
    beat(32'd1, 1'b0);
    beat(32'd2, 1'b0);
    beat(32'd3, 1'b0);
    beat(32'd4, 1'b1);
    step();
    chk("done_held", 64'(done), 64'd1);
    chk("min_frozen", 64'(res_min), 64'd1);
    do_ack();
    chk("min_after_ack", 64'(res_min), 64'd1);
    step();

    // Frame 2: out of order; a beat on the start cycle must not be counted.
    push_exp(32'd3, 32'd12, 32'd9, 40'd40, 1'b1, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'd0;
    do_start(32'd5);
    in_valid = 1'b0;
    beat(32'd7,  1'b0);
    beat(32'd3,  1'b0);
    beat(32'd9,  1'b0);
    beat(32'd9,  1'b0);
    beat(32'd12, 1'b1);
    do_ack();
    step();

    // Illegal counts: 0 and MAX_COUNT+1.
    push_exp(32'd0, 32'd0, 32'd0, 40'd0, 1'b0, 1'b1);
    do_start(32'd0);
    chk("done_cnt0", 64'(done), 64'd1);
    do_ack();
    push_exp(32'd0, 32'd0, 32'd0, 40'd0, 1'b0, 1'b1);
    do_start(32'd102);
    chk("done_cnt102", 64'(done), 64'd1);
    do_ack();
    step();

    // Full-depth frame of all-ones words with random gaps.
    push_exp(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 40'h64_FFFF_FF9B, 1'b0, 1'b0);
    do_start(32'd101);
    for (int i = 0; i < 101; i++) begin
      repeat ($urandom_range(0, 2)) begin
        step();
        chk("done_in_gap", 64'(done), 64'd0);
      end
      beat(32'hFFFF_FFFF, i == 100);
    end
    do_ack();
    step();

    // Reset mid-frame, then a clean 2-word frame.
    do_start(32'd4);
    beat(32'd1,   1'b0);
    beat(32'd100, 1'b0);
    reset = 1'b1;
    step();
    chk_all_zero("midreset");
    reset = 1'b0;
    step();
    push_exp(32'd5, 32'd6, 32'd5, 40'd11, 1'b0, 1'b0);
    do_start(32'd2);
    beat(32'd5, 1'b0);
    beat(32'd6, 1'b1);
    do_ack();
    step();

    // start pulse in COLLECT is ignored; original count=4 frame completes.
    push_exp(32'd2, 32'd8, 32'd4, 40'd20, 1'b0, 1'b0);
    do_start(32'd4);
    beat(32'd2, 1'b0);
    beat(32'd4, 1'b0);
    do_start(32'd3);
    chk("busy_after_ignored_start", 64'(busy), 64'd1);
    beat(32'd6, 1'b0);
    beat(32'd8, 1'b1);
    // ack outside REPORT must not disturb anything after this one closes it.
    do_ack();
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("min_after_stray_ack", 64'(res_min), 64'd2);

    repeat (3) step();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
